// File: rtl/fetch_pkg.sv
// Shared types and constants for the rv32i instruction prefetch unit.
// Queue entries are XLEN wide, so the top-level DataWidth must equal XLEN.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [3:0]  MASK_WORD   = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush. Depth must be a power of two so
// the read and write pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    output fetch_entry_t               data_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the consumer qualifies the head with empty_o.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (32'(count_q) == Depth);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && !flush_i && full_o));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: pipelined imem requests into an in-order prefetch queue,
// with redirect flush and discard of stale in-flight responses.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          DataWidth      = XLEN,
    parameter int unsigned          Depth          = 4,
    parameter int unsigned          MaxOutstanding = 2,
    parameter logic [DataWidth-1:0] ResetVector    = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [DataWidth-1:0] redirect_address_i,
    output logic                 imem_request_o,
    input  logic                 imem_gnt_i,
    output logic [DataWidth-1:0] imem_address_o,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i,
    output logic                 we_re_o,
    output logic [3:0]           mask_o,
    output logic                 instr_valid_o,
    output logic [DataWidth-1:0] instruction_o,
    output logic [DataWidth-1:0] instr_pc_o,
    output logic [DataWidth-1:0] pre_address_pc_o,
    input  logic                 decode_ready_i
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
    logic [DataWidth-1:0] resp_pc_q, resp_pc_d;
    logic [OutW-1:0]      outstanding_q, outstanding_d;
    logic [OutW-1:0]      discard_q, discard_d;
    logic [CntW-1:0]      count;
    logic                 fifo_empty, fifo_full;
    logic                 grant, push, pop;
    logic [DataWidth-1:0] redirect_pc;
    logic                 unused_addr_bits;
    fetch_entry_t         push_entry, head;

    assign redirect_pc      = {redirect_address_i[DataWidth-1:2], 2'b00};
    assign unused_addr_bits = ^redirect_address_i[1:0];

    // Credit rule: queued plus in-flight never exceeds Depth, so pushes cannot overflow.
    assign imem_request_o = !rst_i && !redirect_i && !stall_i
                          && (32'(outstanding_q) < MaxOutstanding)
                          && ((32'(count) + 32'(outstanding_q)) < Depth);
    assign imem_address_o = fetch_pc_q;
    assign grant          = imem_request_o && imem_gnt_i;

    assign push       = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign pop        = instr_valid_o && decode_ready_i && !redirect_i;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + OutW'(grant) - OutW'(imem_rvalid_i);
        if (redirect_i) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Every response still owed after this cycle belongs to the old stream.
            discard_d  = outstanding_q - OutW'(imem_rvalid_i) + OutW'(grant);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + DataWidth'(INSTR_BYTES);
            if (push)  resp_pc_d  = resp_pc_q + DataWidth'(INSTR_BYTES);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= ResetVector;
            resp_pc_q     <= ResetVector;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign instr_valid_o    = !fifo_empty;
    assign instruction_o    = instr_valid_o ? head.instr : '0;
    assign instr_pc_o       = instr_valid_o ? head.pc : '0;
    assign pre_address_pc_o = instr_valid_o ? head.pc + DataWidth'(INSTR_BYTES) : '0;
    assign we_re_o          = 1'b0;
    assign mask_o           = MASK_WORD;

    a_rvalid_owed: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (outstanding_q == '0)));
    a_discard_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        discard_q <= outstanding_q);
    a_full_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_full && imem_request_o));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed table and sequences plus random traffic,
// all checked against a stream-level model of the fetch queue.
module tb_fetch_prefetch_unit;

    localparam int unsigned Depth  = 4;
    localparam int unsigned MaxOut = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_address_i = '0;
    logic        imem_request_o;
    logic        imem_gnt_i = 1'b0;
    logic [31:0] imem_address_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        we_re_o;
    logic [3:0]  mask_o;
    logic        instr_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pre_address_pc_o;
    logic        decode_ready_i = 1'b0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .DataWidth      (32),
        .Depth          (Depth),
        .MaxOutstanding (MaxOut),
        .ResetVector    (32'h0000_0000)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .stall_i            (stall_i),
        .redirect_i         (redirect_i),
        .redirect_address_i (redirect_address_i),
        .imem_request_o     (imem_request_o),
        .imem_gnt_i         (imem_gnt_i),
        .imem_address_o     (imem_address_o),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i),
        .we_re_o            (we_re_o),
        .mask_o             (mask_o),
        .instr_valid_o      (instr_valid_o),
        .instruction_o      (instruction_o),
        .instr_pc_o         (instr_pc_o),
        .pre_address_pc_o   (pre_address_pc_o),
        .decode_ready_i     (decode_ready_i)
    );

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } flight_t;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_q[$];      // addresses the DUT has had granted, awaiting response
    logic [31:0] m_q[$];        // model prefetch queue (pcs)
    flight_t     m_fl[$];       // model in-flight requests
    logic [31:0] m_pc = 32'h0;
    logic [31:0] delivered[$];
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;
    vec_t        tbl[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] ra,
                        input logic rdy, input logic g, input logic rv);
        logic    exp_req, grant_dut, rv_now, had;
        flight_t e;
        @(negedge clk);
        rst_i              = rs;
        stall_i            = st;
        redirect_i         = rd;
        redirect_address_i = ra;
        decode_ready_i     = rdy;
        imem_gnt_i         = g;
        imem_rvalid_i      = rv && !rs && (mem_q.size() != 0);
        imem_rdata_i       = imem_rvalid_i ? mem_word(mem_q[0]) : 32'h0;
        #1;
        s_req   = imem_request_o;
        s_addr  = imem_address_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        chk("mask", 32'(mask_o), 32'hF);
        chk("we_re", 32'(we_re_o), 32'h0);
        exp_req = !rs && !rd && !st && (m_fl.size() < MaxOut)
                  && ((m_q.size() + m_fl.size()) < Depth);
        chk("imem_request", 32'(imem_request_o), 32'(exp_req));
        if (!rs) begin
            chk("imem_address", imem_address_o, m_pc);
            chk("instr_valid", 32'(instr_valid_o), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("instr_pc", instr_pc_o, m_q[0]);
                chk("instruction", instruction_o, mem_word(m_q[0]));
                chk("pre_address_pc", pre_address_pc_o, m_q[0] + 32'd4);
            end
            if (instr_valid_o && rdy && !rd) delivered.push_back(instr_pc_o);
        end
        grant_dut = imem_request_o && g;
        rv_now    = imem_rvalid_i;
        @(posedge clk);
        if (rs) begin
            mem_q.delete();
            m_q.delete();
            m_fl.delete();
            m_pc = 32'h0;
        end else begin
            if (rv_now) void'(mem_q.pop_front());
            if (grant_dut) mem_q.push_back(imem_address_o);
            had = (m_q.size() != 0);
            if (rv_now && m_fl.size() != 0) begin
                e = m_fl.pop_front();
                if (!rd && !e.stale) m_q.push_back(e.pc);
            end
            if (rd) begin
                for (int i = 0; i < m_fl.size(); i++) begin
                    e = m_fl[i];
                    e.stale = 1'b1;
                    m_fl[i] = e;
                end
                m_q.delete();
                m_pc = {ra[31:2], 2'b00};
            end else begin
                if (had && rdy) void'(m_q.pop_front());
                if (exp_req && g) begin
                    e.pc = m_pc;
                    e.stale = 1'b0;
                    m_fl.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic run(input int n, input logic st, input logic rdy, input logic g,
                       input logic rv);
        for (int i = 0; i < n; i++) step(1'b0, st, 1'b0, 32'h0, rdy, g, rv);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n_req;
        tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 32'h0C, 1'b1, 32'h4};
        tbl[4] = '{1'b1, 32'h10, 1'b1, 32'h8};
        tbl[5] = '{1'b1, 32'h14, 1'b1, 32'hC};

        // Zero-latency memory: one instruction per cycle, first valid two cycles in.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            chk($sformatf("t1_req[%0d]", i), 32'(s_req), 32'(tbl[i].exp_req));
            chk($sformatf("t1_addr[%0d]", i), s_addr, tbl[i].exp_addr);
            chk($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("t1_pc[%0d]", i), s_pc, tbl[i].exp_pc);
        end

        // Decode blocked: credit limits fetch to four words, then drain in order.
        do_reset();
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            n_req += int'(s_req);
        end
        chk("t2_requests", 32'(n_req), 32'd4);
        chk("t2_req_low", 32'(s_req), 32'd0);
        delivered.delete();
        run(6, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t2_drain_cnt", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            chk($sformatf("t2_drain[%0d]", i), delivered[i], 32'(i * 4));

        // Redirect with two requests in flight: both responses discarded.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0);
        chk("t3_req_in_redirect", 32'(s_req), 32'd0);
        delivered.delete();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t3_addr", s_addr, 32'h100);
        run(8, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t3_deliv_cnt", 32'(delivered.size() != 0), 32'd1);
        if (delivered.size() != 0) chk("t3_first_pc", delivered[0], 32'h100);

        // Redirect coinciding with a response while two are outstanding.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_valid", 32'(s_valid), 32'd0);
        chk("t4_req", 32'(s_req), 32'd1);
        chk("t4_addr", s_addr, 32'h200);

        // Stall blocks requests but responses and decode continue.
        do_reset();
        run(2, 1'b0, 1'b1, 1'b1, 1'b0);
        delivered.delete();
        n_req = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            n_req += int'(s_req);
        end
        chk("t5_stall_reqs", 32'(n_req), 32'd0);
        chk("t5_deliv_cnt", 32'(delivered.size()), 32'd2);
        if (delivered.size() == 2) begin
            chk("t5_deliv0", delivered[0], 32'h0);
            chk("t5_deliv1", delivered[1], 32'h4);
        end
        run(1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_resume_req", 32'(s_req), 32'd1);
        chk("t5_resume_addr", s_addr, 32'h8);

        // Reset mid-stream with three queued and one in flight.
        do_reset();
        run(4, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        delivered.delete();
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_valid", 32'(s_valid), 32'd0);
        chk("t6_addr", s_addr, 32'h0);
        run(6, 1'b0, 1'b1, 1'b1, 1'b1);
        if (delivered.size() != 0) chk("t6_first_pc", delivered[0], 32'h0);
        else chk("t6_deliv_cnt", 32'(delivered.size()), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 5) == 0, ($urandom % 25) == 0,
                 $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
